// File: rtl/decode_ctrl_stage.sv
// rtl/decode_ctrl_stage.sv - registered RV32I/Zicsr/M decode stage with valid/ready and MD/WFI sequencing

package Common;
  typedef enum logic [3:0] {
    MEM_NOP = 4'd0, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW
  } mem_type_t;

  typedef enum logic [3:0] {
    alu_add = 4'd0, alu_sub, alu_sll, alu_slt, alu_sltu, alu_xor, alu_srl, alu_sra, alu_or, alu_and
  } alu_op_t;

  typedef enum logic [2:0] {
    br_none = 3'd0, br_ce, br_cne, br_slt, br_cge, br_sltu, br_cgeu
  } br_cond_t;

  // regData: 00 alu result, 01 pc+4, 10 csr read data, 11 immediate
  typedef struct packed {
    mem_type_t   instType;
    alu_op_t     alu_op;
    logic        alu_from_imm;
    logic        alu_from_pc;
    logic        reg_write;
    logic        mem_to_reg;
    logic [1:0]  regData;
    logic        is_branch;
    br_cond_t    br_cond;
    logic        is_jump;
    logic        is_md;
    logic        is_wfi;
    logic        exception;
    logic        excRet;
    logic        inst_invalid;
    logic [31:0] excCause;
    logic        csr_en;
    logic        csr_source;
    logic [1:0]  csr_op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } control_out_t;
endpackage

module decode_ctrl_stage #(
  parameter int XLEN    = 32,
  parameter int EN_M    = 1,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 34
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [31:0]         instr_i,
  input  logic [XLEN-1:0]     pc_i,
  input  logic                irq_pending_i,
  input  logic                flush_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output Common::control_out_t ctrl_o,
  output logic [XLEN-1:0]     imm_o,
  output logic [XLEN-1:0]     pc_o,
  output logic [2:0]          md_op_o,
  output logic                md_start_o,
  output logic                md_busy_o
);
  import Common::*;

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT) + 1;
  localparam logic [CW-1:0] MUL_INIT = CW'(MUL_LAT - 2);
  localparam logic [CW-1:0] DIV_INIT = CW'(DIV_LAT - 2);

  typedef enum logic [1:0] {IDLE, MD_WAIT, WFI_WAIT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            valid_d, busy_d, start_d;
  logic            accept;

  control_out_t    dec;
  logic [31:0]     imm32;
  logic            illegal;
  logic            dec_md;
  logic            lat_one;
  logic [CW-1:0]   cnt_init;

  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [31:0]     imm_i, imm_s, imm_b, imm_u, imm_j;

  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];
  assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b  = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u  = {instr_i[31:12], 12'b0};
  assign imm_j  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

  // funct3 to ALU operation; sub_ok distinguishes OP (SUB allowed) from OP-IMM
  function automatic alu_op_t alu_sel(input logic [2:0] f3, input logic b30, input logic sub_ok);
    case (f3)
      3'b000:  alu_sel = (sub_ok && b30) ? alu_sub : alu_add;
      3'b001:  alu_sel = alu_sll;
      3'b010:  alu_sel = alu_slt;
      3'b011:  alu_sel = alu_sltu;
      3'b100:  alu_sel = alu_xor;
      3'b101:  alu_sel = b30 ? alu_sra : alu_srl;
      3'b110:  alu_sel = alu_or;
      default: alu_sel = alu_and;
    endcase
  endfunction

  // combinational decode of the offered instruction
  always_comb begin
    dec      = '0;
    imm32    = '0;
    illegal  = 1'b0;
    dec_md   = 1'b0;
    dec.rd   = instr_i[11:7];
    dec.rs1  = instr_i[19:15];
    dec.rs2  = instr_i[24:20];
    case (instr_i[6:2])
      5'b00000: begin
        dec.alu_from_imm = 1'b1;
        dec.reg_write    = 1'b1;
        dec.mem_to_reg   = 1'b1;
        imm32            = imm_i;
        case (funct3)
          3'b000:  dec.instType = MEM_LB;
          3'b001:  dec.instType = MEM_LH;
          3'b010:  dec.instType = MEM_LW;
          3'b100:  dec.instType = MEM_LBU;
          3'b101:  dec.instType = MEM_LHU;
          default: illegal = 1'b1;
        endcase
      end
      5'b00011: begin
      end
      5'b00100: begin
        dec.alu_op       = alu_sel(funct3, instr_i[30], 1'b0);
        dec.alu_from_imm = 1'b1;
        dec.reg_write    = 1'b1;
        imm32            = imm_i;
      end
      5'b00101: begin
        dec.alu_from_imm = 1'b1;
        dec.alu_from_pc  = 1'b1;
        dec.reg_write    = 1'b1;
        imm32            = imm_u;
      end
      5'b01000: begin
        dec.alu_from_imm = 1'b1;
        imm32            = imm_s;
        case (funct3)
          3'b000:  dec.instType = MEM_SB;
          3'b001:  dec.instType = MEM_SH;
          3'b010:  dec.instType = MEM_SW;
          default: illegal = 1'b1;
        endcase
      end
      5'b01100: begin
        if (funct7 == 7'b0000001) begin
          if (EN_M != 0) begin
            dec_md        = 1'b1;
            dec.is_md     = 1'b1;
            dec.reg_write = 1'b1;
          end else begin
            illegal = 1'b1;
          end
        end else begin
          dec.alu_op    = alu_sel(funct3, instr_i[30], 1'b1);
          dec.reg_write = 1'b1;
        end
      end
      5'b01101: begin
        dec.reg_write = 1'b1;
        dec.regData   = 2'b11;
        imm32         = imm_u;
      end
      5'b11000: begin
        dec.is_branch = 1'b1;
        dec.alu_op    = alu_sub;
        imm32         = imm_b;
        case (funct3)
          3'b000:  dec.br_cond = br_ce;
          3'b001:  dec.br_cond = br_cne;
          3'b100:  dec.br_cond = br_slt;
          3'b101:  dec.br_cond = br_cge;
          3'b110:  dec.br_cond = br_sltu;
          3'b111:  dec.br_cond = br_cgeu;
          default: illegal = 1'b1;
        endcase
      end
      5'b11001: begin
        dec.alu_from_imm = 1'b1;
        dec.reg_write    = 1'b1;
        dec.regData      = 2'b01;
        dec.is_jump      = 1'b1;
        imm32            = imm_i;
        if (funct3 != 3'b000) illegal = 1'b1;
      end
      5'b11011: begin
        dec.alu_from_imm = 1'b1;
        dec.alu_from_pc  = 1'b1;
        dec.reg_write    = 1'b1;
        dec.regData      = 2'b01;
        dec.is_jump      = 1'b1;
        imm32            = imm_j;
      end
      5'b11100: begin
        imm32 = imm_i;
        if (funct3 == 3'b000) begin
          case (instr_i[31:20])
            12'h000: begin dec.exception = 1'b1; dec.excCause = 32'd11; end
            12'h001: begin dec.exception = 1'b1; dec.excCause = 32'd3;  end
            12'h302: dec.excRet = 1'b1;
            12'h105: dec.is_wfi = 1'b1;
            default: illegal = 1'b1;
          endcase
        end else if (funct3 == 3'b100) begin
          illegal = 1'b1;
        end else begin
          dec.csr_en     = 1'b1;
          dec.reg_write  = 1'b1;
          dec.regData    = 2'b10;
          dec.csr_source = ~funct3[2];
          dec.csr_op     = funct3[1:0];
        end
      end
      default: illegal = 1'b1;
    endcase
    if (instr_i[1:0] != 2'b11) illegal = 1'b1;
    if (illegal) begin
      dec              = '0;
      dec.inst_invalid = 1'b1;
      dec.exception    = 1'b1;
      dec.excCause     = 32'h2;
      dec_md           = 1'b0;
    end
  end

  assign lat_one  = instr_i[14] ? (DIV_LAT == 1) : (MUL_LAT == 1);
  assign cnt_init = instr_i[14] ? DIV_INIT : MUL_INIT;

  assign in_ready_o = (state_q == IDLE) && !flush_i && (!out_valid_o || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;

  // next-state and handshake flags; flush overrides everything
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = out_valid_o && !out_ready_i;
    busy_d  = md_busy_o;
    start_d = 1'b0;
    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      valid_d = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            start_d = dec_md;
            if (dec_md && !lat_one) begin
              state_d = MD_WAIT;
              cnt_d   = cnt_init;
              busy_d  = 1'b1;
              valid_d = 1'b0;
            end else if (dec.is_wfi && !irq_pending_i) begin
              state_d = WFI_WAIT;
              valid_d = 1'b0;
            end else begin
              valid_d = 1'b1;
            end
          end
        end
        MD_WAIT: begin
          if (cnt_q == '0) begin
            state_d = IDLE;
            valid_d = 1'b1;
            busy_d  = 1'b0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        WFI_WAIT: begin
          if (irq_pending_i) begin
            state_d = IDLE;
            valid_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // state, counter and handshake registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_o <= 1'b0;
      md_busy_o   <= 1'b0;
      md_start_o  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_o <= valid_d;
      md_busy_o   <= busy_d;
      md_start_o  <= start_d;
    end
  end

  // bundle registers load only on acceptance, so they hold during back-pressure
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_o  <= '0;
      imm_o   <= '0;
      pc_o    <= '0;
      md_op_o <= 3'b000;
    end else if (accept) begin
      ctrl_o  <= dec;
      imm_o   <= XLEN'($signed(imm32));
      pc_o    <= pc_i;
      md_op_o <= dec_md ? funct3 : 3'b000;
    end
  end

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// tb/tb_decode_ctrl_stage.sv - self-checking bench for decode_ctrl_stage
module tb_decode_ctrl_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, in_valid, in_ready, irq, flush, out_valid, out_ready, md_start, md_busy;
  logic [31:0] instr, pc_in, imm_o, pc_o;
  logic [2:0]  md_op;
  Common::control_out_t ctrl;

  logic in_valid_b, in_ready_b, out_valid_b, md_start_b, md_busy_b;
  logic [31:0] instr_b, imm_b, pc_o_b;
  logic [2:0]  md_op_b;
  Common::control_out_t ctrl_b;

  int checks = 0;
  int failures = 0;

  decode_ctrl_stage #(.XLEN(32), .EN_M(1), .MUL_LAT(3), .DIV_LAT(34)) dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .instr_i(instr), .pc_i(pc_in), .irq_pending_i(irq), .flush_i(flush),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .ctrl_o(ctrl), .imm_o(imm_o),
    .pc_o(pc_o), .md_op_o(md_op), .md_start_o(md_start), .md_busy_o(md_busy));

  decode_ctrl_stage #(.XLEN(32), .EN_M(0), .MUL_LAT(3), .DIV_LAT(34)) dut_nom (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid_b), .in_ready_o(in_ready_b),
    .instr_i(instr_b), .pc_i(32'h40), .irq_pending_i(1'b0), .flush_i(1'b0),
    .out_valid_o(out_valid_b), .out_ready_i(1'b1), .ctrl_o(ctrl_b), .imm_o(imm_b),
    .pc_o(pc_o_b), .md_op_o(md_op_b), .md_start_o(md_start_b), .md_busy_o(md_busy_b));

  // instruction-set rule table (mask/match, first match wins)
  typedef struct {
    logic [31:0] mask;
    logic [31:0] match;
    Common::mem_type_t mt;
    bit rw;
    logic [1:0] rsel;
    bit br;
    int fmt;            // 0 none, 1 I, 2 S, 3 B, 4 U, 5 J
    logic [31:0] cause;
    bit md;
  } rule_t;
  rule_t rules[$];

  localparam logic [31:0] OPC = 32'h0000_007F, F3 = 32'h0000_7000;
  localparam logic [31:0] F7 = 32'hFE00_0000, I12 = 32'hFFF0_0000;

  task automatic add_rule(input logic [31:0] mask, input logic [31:0] match, input Common::mem_type_t mt,
                          input bit rw, input logic [1:0] rsel, input bit br, input int fmt,
                          input logic [31:0] cause, input bit md);
    rule_t r;
    r.mask = mask; r.match = match; r.mt = mt; r.rw = rw; r.rsel = rsel; r.br = br;
    r.fmt = fmt; r.cause = cause; r.md = md;
    rules.push_back(r);
  endtask

  task automatic build_rules();
    logic [2:0] ld_f3[5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    Common::mem_type_t ld_mt[5] = '{Common::MEM_LB, Common::MEM_LH, Common::MEM_LW, Common::MEM_LBU, Common::MEM_LHU};
    Common::mem_type_t st_mt[3] = '{Common::MEM_SB, Common::MEM_SH, Common::MEM_SW};
    logic [2:0] br_f3[6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [2:0] csr_f3[6] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
    for (int i = 0; i < 5; i++) add_rule(OPC|F3, 32'h03 | (32'(ld_f3[i]) << 12), ld_mt[i], 1, 2'b00, 0, 1, 0, 0);
    add_rule(OPC, 32'h0F, Common::MEM_NOP, 0, 2'b00, 0, 0, 0, 0);
    add_rule(OPC, 32'h13, Common::MEM_NOP, 1, 2'b00, 0, 1, 0, 0);
    add_rule(OPC, 32'h17, Common::MEM_NOP, 1, 2'b00, 0, 4, 0, 0);
    for (int i = 0; i < 3; i++) add_rule(OPC|F3, 32'h23 | (32'(i) << 12), st_mt[i], 0, 2'b00, 0, 2, 0, 0);
    add_rule(OPC|F7, 32'h33 | (32'd1 << 25), Common::MEM_NOP, 1, 2'b00, 0, 0, 0, 1);
    add_rule(OPC, 32'h33, Common::MEM_NOP, 1, 2'b00, 0, 0, 0, 0);
    add_rule(OPC, 32'h37, Common::MEM_NOP, 1, 2'b11, 0, 4, 0, 0);
    for (int i = 0; i < 6; i++) add_rule(OPC|F3, 32'h63 | (32'(br_f3[i]) << 12), Common::MEM_NOP, 0, 2'b00, 1, 3, 0, 0);
    add_rule(OPC|F3, 32'h67, Common::MEM_NOP, 1, 2'b01, 0, 1, 0, 0);
    add_rule(OPC, 32'h6F, Common::MEM_NOP, 1, 2'b01, 0, 5, 0, 0);
    add_rule(OPC|F3|I12, 32'h0000_0073, Common::MEM_NOP, 0, 2'b00, 0, 1, 11, 0);
    add_rule(OPC|F3|I12, 32'h0010_0073, Common::MEM_NOP, 0, 2'b00, 0, 1, 3, 0);
    add_rule(OPC|F3|I12, 32'h3020_0073, Common::MEM_NOP, 0, 2'b00, 0, 1, 0, 0);
    add_rule(OPC|F3|I12, 32'h1050_0073, Common::MEM_NOP, 0, 2'b00, 0, 1, 0, 0);
    for (int i = 0; i < 6; i++) add_rule(OPC|F3, 32'h73 | (32'(csr_f3[i]) << 12), Common::MEM_NOP, 1, 2'b10, 0, 1, 0, 0);
  endtask

  function automatic bit ref_lookup(input logic [31:0] ins, output rule_t r);
    r = rules[0];
    for (int i = 0; i < rules.size(); i++)
      if ((ins & rules[i].mask) == rules[i].match) begin r = rules[i]; return 1'b1; end
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] ins, input int fmt);
    int v;
    case (fmt)
      1: v = $signed(ins) >>> 20;
      2: v = (($signed(ins) >>> 25) * 32) + int'(ins[11:7]);
      3: v = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
      4: v = ins & 32'hFFFF_F000;
      5: v = (ins[31] ? -1048576 : 0) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
      default: v = 0;
    endcase
    return v;
  endfunction

  // present one instruction at a negedge, return after the accepting posedge at the next negedge
  task automatic issue(input logic [31:0] ins, input logic [31:0] pc, output bit rdy);
    in_valid = 1'b1; instr = ins; pc_in = pc;
    #1 rdy = in_ready;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (md_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", md_busy); end
    checks++; if (md_start !== 1'b0) begin failures++; $display("FAIL reset_start got=%b exp=0", md_start); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    checks++; if (ctrl !== Common::control_out_t'(0)) begin failures++; $display("FAIL reset_ctrl got=%h exp=0", ctrl); end
    checks++; if (ctrl.instType !== Common::MEM_NOP) begin failures++; $display("FAIL reset_insttype got=%0d exp=0", ctrl.instType); end
    checks++; if ({imm_o, pc_o, md_op} !== 67'd0) begin failures++; $display("FAIL reset_data got=%h/%h/%h exp=0", imm_o, pc_o, md_op); end
  endtask

  task automatic test_back_to_back();
    bit rdy;
    @(negedge clk);
    issue(32'h0050_0093, 32'h1000, rdy);
    checks++; if (!rdy) begin failures++; $display("FAIL b2b_ready1 got=0 exp=1"); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid1 got=%b exp=1", out_valid); end
    checks++; if (ctrl.alu_op !== Common::alu_add || ctrl.alu_from_imm !== 1'b1 || ctrl.reg_write !== 1'b1)
      begin failures++; $display("FAIL b2b_addi_ctrl got=%0d/%b/%b exp=0/1/1", ctrl.alu_op, ctrl.alu_from_imm, ctrl.reg_write); end
    checks++; if (imm_o !== 32'd5) begin failures++; $display("FAIL b2b_addi_imm got=%h exp=5", imm_o); end
    issue(32'h0010_A023, 32'h1004, rdy);
    checks++; if (!rdy) begin failures++; $display("FAIL b2b_ready2 got=0 exp=1"); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid2 got=%b exp=1", out_valid); end
    checks++; if (ctrl.instType !== Common::MEM_SW) begin failures++; $display("FAIL b2b_sw_type got=%0d exp=%0d", ctrl.instType, Common::MEM_SW); end
    checks++; if (imm_o !== 32'd0 || pc_o !== 32'h1004) begin failures++; $display("FAIL b2b_sw_imm_pc got=%h/%h exp=0/1004", imm_o, pc_o); end
  endtask

  task automatic test_mul();
    bit rdy;
    @(negedge clk);
    issue(32'h0220_80B3, 32'h2000, rdy);
    checks++; if ({md_start, md_busy, in_ready, out_valid} !== 4'b1100) begin failures++; $display("FAIL mul_t1 got=%b exp=1100", {md_start, md_busy, in_ready, out_valid}); end
    @(negedge clk);
    checks++; if ({md_start, md_busy, in_ready, out_valid} !== 4'b0100) begin failures++; $display("FAIL mul_t2 got=%b exp=0100", {md_start, md_busy, in_ready, out_valid}); end
    @(negedge clk);
    checks++; if ({md_start, md_busy, out_valid} !== 3'b001) begin failures++; $display("FAIL mul_t3 got=%b exp=001", {md_start, md_busy, out_valid}); end
    checks++; if (md_op !== 3'b000 || ctrl.is_md !== 1'b1) begin failures++; $display("FAIL mul_op got=%b/%b exp=000/1", md_op, ctrl.is_md); end
  endtask

  task automatic test_div_flush();
    bit rdy;
    @(negedge clk);
    issue(32'h0220_C0B3, 32'h3000, rdy);
    checks++; if (md_op !== 3'b100 || md_start !== 1'b1) begin failures++; $display("FAIL div_start got=%b/%b exp=100/1", md_op, md_start); end
    repeat (4) @(negedge clk);
    flush = 1'b1;
    #1;
    checks++; if (md_busy !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL div_busy_t5 got=%b/%b exp=1/0", md_busy, in_ready); end
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++; if ({out_valid, md_busy, in_ready} !== 3'b001) begin failures++; $display("FAIL div_flush_t6 got=%b exp=001", {out_valid, md_busy, in_ready}); end
    issue(32'h0020_81B3, 32'h3004, rdy);
    checks++; if (!rdy) begin failures++; $display("FAIL div_add_ready got=0 exp=1"); end
    checks++; if (out_valid !== 1'b1 || ctrl.alu_op !== Common::alu_add || md_start !== 1'b0 || pc_o !== 32'h3004)
      begin failures++; $display("FAIL div_add_lat1 got=%b/%0d/%b/%h exp=1/0/0/3004", out_valid, ctrl.alu_op, md_start, pc_o); end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0 || md_start !== 1'b0) begin failures++; $display("FAIL div_abandoned cyc=%0d got=%b/%b exp=0/0", k, out_valid, md_start); end
    end
  endtask

  task automatic test_wfi();
    bit rdy;
    @(negedge clk);
    irq = 1'b0;
    issue(32'h1050_0073, 32'h4000, rdy);
    for (int k = 0; k < 8; k++) begin
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("FAIL wfi_wait cyc=%0d got=%b/%b exp=0/0", k, out_valid, in_ready); end
      @(negedge clk);
    end
    irq = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL wfi_early got=%b exp=0", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || ctrl.is_wfi !== 1'b1) begin failures++; $display("FAIL wfi_wake got=%b/%b exp=1/1", out_valid, ctrl.is_wfi); end
    issue(32'h1050_0073, 32'h4004, rdy);
    checks++; if (!rdy || out_valid !== 1'b1 || pc_o !== 32'h4004) begin failures++; $display("FAIL wfi_irq_lat1 got=%b/%b/%h exp=1/1/4004", rdy, out_valid, pc_o); end
  endtask

  task automatic test_illegal();
    bit rdy;
    @(negedge clk);
    issue(32'hFFFF_FFFF, 32'h5000, rdy);
    checks++; if (out_valid !== 1'b1 || ctrl.inst_invalid !== 1'b1 || ctrl.excCause !== 32'h2 ||
                  ctrl.reg_write !== 1'b0 || ctrl.instType !== Common::MEM_NOP)
      begin failures++; $display("FAIL illegal_ones got=%b/%b/%h/%b/%0d exp=1/1/2/0/0", out_valid, ctrl.inst_invalid, ctrl.excCause, ctrl.reg_write, ctrl.instType); end
    in_valid_b = 1'b1; instr_b = 32'h0220_80B3;
    @(posedge clk);
    @(negedge clk);
    in_valid_b = 1'b0;
    checks++; if (out_valid_b !== 1'b1 || ctrl_b.inst_invalid !== 1'b1 || ctrl_b.excCause !== 32'h2 ||
                  ctrl_b.reg_write !== 1'b0 || ctrl_b.instType !== Common::MEM_NOP)
      begin failures++; $display("FAIL illegal_mul_nom got=%b/%b/%h/%b/%0d exp=1/1/2/0/0", out_valid_b, ctrl_b.inst_invalid, ctrl_b.excCause, ctrl_b.reg_write, ctrl_b.instType); end
    checks++; if (md_start_b !== 1'b0 || md_busy_b !== 1'b0 || md_op_b !== 3'b000) begin failures++; $display("FAIL illegal_mul_nom_md got=%b/%b/%b exp=0/0/000", md_start_b, md_busy_b, md_op_b); end
  endtask

  task automatic test_stall();
    bit rdy;
    @(negedge clk);
    out_ready = 1'b0;
    issue(32'hFF90_8113, 32'h100, rdy);
    in_valid = 1'b1; instr = 32'h1234_50B7; pc_in = 32'h104;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL stall_hs cyc=%0d got=%b/%b exp=1/0", k, out_valid, in_ready); end
      checks++; if (imm_o !== 32'hFFFF_FFF9 || pc_o !== 32'h100 || ctrl.rd !== 5'd2 || ctrl.regData !== 2'b00 || ctrl.alu_from_imm !== 1'b1)
        begin failures++; $display("FAIL stall_hold cyc=%0d got=%h/%h/%0d/%b exp=fffffff9/100/2/00", k, imm_o, pc_o, ctrl.rd, ctrl.regData); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || imm_o !== 32'h1234_5000 || ctrl.regData !== 2'b11 || pc_o !== 32'h104)
      begin failures++; $display("FAIL stall_replace got=%b/%h/%b/%h exp=1/12345000/11/104", out_valid, imm_o, ctrl.regData, pc_o); end
  endtask

  task automatic test_random();
    logic [6:0] opcs[11] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};
    logic [11:0] sys_imm[5] = '{12'h000, 12'h001, 12'h302, 12'h105, 12'h7C0};
    logic [31:0] ins, pc;
    rule_t r;
    bit legal, rdy, exp_start;
    int lat, exp_lat;
    @(negedge clk);
    for (int n = 0; n < 80; n++) begin
      ins = $urandom;
      if ($urandom_range(0, 9) != 0) begin
        ins[6:0] = opcs[$urandom_range(0, 10)];
        if (ins[6:0] == 7'h33 && $urandom_range(0, 2) == 0) ins[31:25] = 7'b0000001;
        if (ins[6:0] == 7'h73 && $urandom_range(0, 1) == 0) begin
          ins[14:12] = 3'b000;
          ins[31:20] = sys_imm[$urandom_range(0, 4)];
        end
      end
      pc = $urandom;
      legal = ref_lookup(ins, r);
      exp_start = legal && r.md;
      exp_lat = exp_start ? (ins[14] ? 34 : 3) : 1;
      issue(ins, pc, rdy);
      checks++; if (!rdy) begin failures++; $display("FAIL rnd_ready n=%0d ins=%h got=0 exp=1", n, ins); end
      checks++; if (md_start !== exp_start) begin failures++; $display("FAIL rnd_start n=%0d ins=%h got=%b exp=%b", n, ins, md_start, exp_start); end
      lat = 1;
      while (out_valid !== 1'b1 && lat < 100) begin
        @(negedge clk);
        lat++;
      end
      checks++; if (lat != exp_lat) begin failures++; $display("FAIL rnd_latency n=%0d ins=%h got=%0d exp=%0d", n, ins, lat, exp_lat); end
      checks++; if (ctrl.inst_invalid !== !legal || pc_o !== pc) begin failures++; $display("FAIL rnd_valid_pc n=%0d ins=%h got=%b/%h exp=%b/%h", n, ins, ctrl.inst_invalid, pc_o, !legal, pc); end
      if (legal) begin
        checks++; if (ctrl.reg_write !== r.rw || ctrl.instType !== r.mt || ctrl.regData !== r.rsel || ctrl.is_branch !== r.br || ctrl.excCause !== r.cause)
          begin failures++; $display("FAIL rnd_ctrl n=%0d ins=%h got=%b/%0d/%b/%b/%0d exp=%b/%0d/%b/%b/%0d", n, ins,
                 ctrl.reg_write, ctrl.instType, ctrl.regData, ctrl.is_branch, ctrl.excCause, r.rw, r.mt, r.rsel, r.br, r.cause); end
        checks++; if (imm_o !== ref_imm(ins, r.fmt)) begin failures++; $display("FAIL rnd_imm n=%0d ins=%h got=%h exp=%h", n, ins, imm_o, ref_imm(ins, r.fmt)); end
        checks++; if (md_op !== (r.md ? ins[14:12] : 3'b000)) begin failures++; $display("FAIL rnd_mdop n=%0d ins=%h got=%b", n, ins, md_op); end
      end else begin
        checks++; if (ctrl.reg_write !== 1'b0 || ctrl.instType !== Common::MEM_NOP || ctrl.excCause !== 32'h2)
          begin failures++; $display("FAIL rnd_illegal n=%0d ins=%h got=%b/%0d/%h exp=0/0/2", n, ins, ctrl.reg_write, ctrl.instType, ctrl.excCause); end
      end
    end
  endtask

  task automatic test_reset_mid_div();
    bit rdy;
    @(negedge clk);
    issue(32'h0220_C0B3, 32'h6000, rdy);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || md_busy !== 1'b0) begin failures++; $display("FAIL rstdiv_async got=%b/%b exp=0/0", out_valid, md_busy); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1 || md_busy !== 1'b0) begin failures++; $display("FAIL rstdiv_release got=%b/%b exp=1/0", in_ready, md_busy); end
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstdiv_stale cyc=%0d got=%b exp=0", k, out_valid); end
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; instr = '0; pc_in = '0; irq = 1'b1; flush = 1'b0; out_ready = 1'b1;
    in_valid_b = 1'b0; instr_b = '0;
    build_rules();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_back_to_back();
    test_mul();
    test_div_flush();
    test_wfi();
    test_illegal();
    test_stall();
    test_random();
    test_reset_mid_div();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
